// File: rtl/dot11_tx_scramble_encode.sv
// 802.11a/g/n OFDM TX bit pipeline: assembles SERVICE/PSDU/tail/pad, scrambles with
// x^7+x^4+1 and applies the rate-1/2 K=7 convolutional code, one coded pair per beat.
module dot11_tx_scramble_encode #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] psdu_len,
  input  logic [8:0]           n_dbps,
  input  logic [6:0]           seed,
  input  logic [7:0]           byte_in,
  input  logic                 byte_in_valid,
  output logic                 byte_in_ready,
  output logic [1:0]           bit_out,
  output logic                 bit_out_valid,
  input  logic                 bit_out_ready,
  output logic                 bit_out_sym_end,
  output logic                 bit_out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVICE = 3'd1,
    DATA    = 3'd2,
    TAIL    = 3'd3,
    PAD     = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t               state_r;
  state_t               next_state_s;
  logic [LEN_WIDTH-1:0] len_r;
  logic [LEN_WIDTH-1:0] taken_r;
  logic [8:0]           ndbps_r;
  logic [8:0]           sc_r;
  logic [3:0]           bit_cnt_r;
  logic [6:0]           scr_r;
  logic [5:0]           enc_r;
  logic [7:0]           buf_r;
  logic                 buf_full_r;
  logic [2:0]           bit_idx_r;
  logic                 primed_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 cfg_err_r;
  logic                 out_valid_r;
  logic [1:0]           out_pair_r;
  logic                 out_sym_r;
  logic                 out_last_r;

  logic fb_s, raw_s, u_s, avail_s, advance_s, sym_end_s, last_s;
  logic empty_next_s, ready_s, take_s, byte_done_s, cfg_bad_s, accept_s;

  // enc_r[k-1] holds the scrambled bit k beats ago
  function automatic logic enc_a(input logic u, input logic [5:0] d);
    return u ^ d[1] ^ d[2] ^ d[4] ^ d[5];
  endfunction

  function automatic logic enc_b(input logic u, input logic [5:0] d);
    return u ^ d[0] ^ d[1] ^ d[2] ^ d[5];
  endfunction

  // Bit source selection, handshake qualifiers and next-state decode.
  always_comb begin
    fb_s         = scr_r[6] ^ scr_r[3];
    raw_s        = 1'b0;
    avail_s      = 1'b0;
    next_state_s = state_r;
    case (state_r)
      SERVICE: avail_s = primed_r;
      DATA: begin
        avail_s = buf_full_r;
        raw_s   = buf_r[bit_idx_r];
      end
      TAIL:    avail_s = 1'b1;
      PAD:     avail_s = 1'b1;
      default: avail_s = 1'b0;
    endcase
    u_s          = (state_r == TAIL) ? 1'b0 : (raw_s ^ fb_s);
    advance_s    = avail_s & (~out_valid_r | bit_out_ready);
    sym_end_s    = (sc_r == (ndbps_r - 9'd1));
    last_s       = sym_end_s & ((state_r == PAD) | ((state_r == TAIL) & (bit_cnt_r == 4'd5)));
    byte_done_s  = advance_s & (state_r == DATA) & (bit_idx_r == 3'd7);
    empty_next_s = ~buf_full_r | byte_done_s;
    ready_s      = (state_r == DATA) & empty_next_s & (taken_r < len_r);
    take_s       = ready_s & byte_in_valid;
    cfg_bad_s    = (psdu_len == '0) | (n_dbps == 9'd0);
    accept_s     = (state_r == IDLE) & start & ~cfg_bad_s;

    case (state_r)
      IDLE: begin
        if (accept_s) next_state_s = SERVICE;
        else          next_state_s = IDLE;
      end
      SERVICE: begin
        if (advance_s & (bit_cnt_r == 4'd15)) next_state_s = DATA;
        else                                   next_state_s = SERVICE;
      end
      DATA: begin
        if (byte_done_s & (taken_r == len_r)) next_state_s = TAIL;
        else                                   next_state_s = DATA;
      end
      TAIL: begin
        if (advance_s & (bit_cnt_r == 4'd5)) next_state_s = sym_end_s ? FIN : PAD;
        else                                  next_state_s = TAIL;
      end
      PAD: begin
        if (advance_s & sym_end_s) next_state_s = FIN;
        else                       next_state_s = PAD;
      end
      FIN: begin
        if (out_valid_r & bit_out_ready) next_state_s = IDLE;
        else                             next_state_s = FIN;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register, status pulses and the output beat register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
      out_valid_r <= 1'b0;
      out_pair_r  <= 2'b00;
      out_sym_r   <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      busy_r    <= (next_state_s != IDLE);
      done_r    <= (state_r == FIN) & out_valid_r & bit_out_ready;
      cfg_err_r <= (state_r == IDLE) & start & cfg_bad_s;
      if (advance_s) begin
        out_valid_r <= 1'b1;
        out_pair_r  <= {enc_b(u_s, enc_r), enc_a(u_s, enc_r)};
        out_sym_r   <= sym_end_s;
        out_last_r  <= last_s;
      end else if (bit_out_ready) begin
        out_valid_r <= 1'b0;
        out_pair_r  <= 2'b00;
        out_sym_r   <= 1'b0;
        out_last_r  <= 1'b0;
      end
    end
  end

  // Frame configuration, scrambler/encoder state, counters and byte buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      len_r      <= '0;
      taken_r    <= '0;
      ndbps_r    <= 9'd0;
      sc_r       <= 9'd0;
      bit_cnt_r  <= 4'd0;
      scr_r      <= 7'd0;
      enc_r      <= 6'd0;
      buf_r      <= 8'd0;
      buf_full_r <= 1'b0;
      bit_idx_r  <= 3'd0;
      primed_r   <= 1'b0;
    end else if (accept_s) begin
      len_r      <= psdu_len;
      taken_r    <= '0;
      ndbps_r    <= n_dbps;
      sc_r       <= 9'd0;
      bit_cnt_r  <= 4'd0;
      scr_r      <= (seed == 7'd0) ? 7'h5D : seed;
      enc_r      <= 6'd0;
      buf_r      <= 8'd0;
      buf_full_r <= 1'b0;
      bit_idx_r  <= 3'd0;
      primed_r   <= 1'b0;
    end else begin
      // first generated bit lands one cycle after SERVICE is entered
      primed_r <= 1'b1;
      if (advance_s) begin
        scr_r     <= {scr_r[5:0], fb_s};
        enc_r     <= {enc_r[4:0], u_s};
        sc_r      <= sym_end_s ? 9'd0 : (sc_r + 9'd1);
        bit_cnt_r <= (next_state_s != state_r) ? 4'd0 : (bit_cnt_r + 4'd1);
      end
      if (take_s) begin
        buf_r      <= byte_in;
        buf_full_r <= 1'b1;
        bit_idx_r  <= 3'd0;
        taken_r    <= taken_r + LEN_WIDTH'(1);
      end else if (byte_done_s) begin
        buf_full_r <= 1'b0;
        bit_idx_r  <= 3'd0;
      end else if (advance_s & (state_r == DATA)) begin
        bit_idx_r <= bit_idx_r + 3'd1;
      end
    end
  end

  assign byte_in_ready   = ready_s;
  assign bit_out         = out_pair_r;
  assign bit_out_valid   = out_valid_r;
  assign bit_out_sym_end = out_sym_r;
  assign bit_out_last    = out_last_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign cfg_err         = cfg_err_r;

endmodule
